// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, FSM encoding,
// column strobe patterns and the row/column to key-code decoder.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE = 5'b10000;

    localparam logic [4:0] KEY_0 = 5'h00;
    localparam logic [4:0] KEY_1 = 5'h01;
    localparam logic [4:0] KEY_2 = 5'h02;
    localparam logic [4:0] KEY_3 = 5'h03;
    localparam logic [4:0] KEY_4 = 5'h04;
    localparam logic [4:0] KEY_5 = 5'h05;
    localparam logic [4:0] KEY_6 = 5'h06;
    localparam logic [4:0] KEY_7 = 5'h07;
    localparam logic [4:0] KEY_8 = 5'h08;
    localparam logic [4:0] KEY_9 = 5'h09;
    localparam logic [4:0] KEY_A = 5'h0A;
    localparam logic [4:0] KEY_B = 5'h0B;
    localparam logic [4:0] KEY_C = 5'h0C;
    localparam logic [4:0] KEY_D = 5'h0D;
    localparam logic [4:0] KEY_E = 5'h0E;
    localparam logic [4:0] KEY_F = 5'h0F;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [3:0] COL_C1 = 4'b1110;
    localparam logic [3:0] COL_C2 = 4'b1101;
    localparam logic [3:0] COL_C3 = 4'b1011;
    localparam logic [3:0] COL_C4 = 4'b0111;

    // Exactly one row line pulled low; anything else is idle or a ghost pattern.
    function automatic logic one_low(input logic [3:0] row);
        return ($countones(~row) == 1);
    endfunction

    function automatic logic [4:0] decode_key(input logic [3:0] row, input logic [3:0] col);
        logic [4:0] code;
        code = KEY_NONE;
        case ({row, col})
            {4'b1110, COL_C1}: code = KEY_1;
            {4'b1110, COL_C2}: code = KEY_2;
            {4'b1110, COL_C3}: code = KEY_3;
            {4'b1110, COL_C4}: code = KEY_A;
            {4'b1101, COL_C1}: code = KEY_4;
            {4'b1101, COL_C2}: code = KEY_5;
            {4'b1101, COL_C3}: code = KEY_6;
            {4'b1101, COL_C4}: code = KEY_B;
            {4'b1011, COL_C1}: code = KEY_7;
            {4'b1011, COL_C2}: code = KEY_8;
            {4'b1011, COL_C3}: code = KEY_9;
            {4'b1011, COL_C4}: code = KEY_C;
            {4'b0111, COL_C1}: code = KEY_E;
            {4'b0111, COL_C2}: code = KEY_0;
            {4'b0111, COL_C3}: code = KEY_F;
            {4'b0111, COL_C4}: code = KEY_D;
            default:           code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_div.sv
// Free-running prescaler; strobe marks the last cycle of each column dwell,
// which is when the row lines are sampled.
module keypad_scan_div #(
    parameter int SCAN_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    output logic strobe
);

    logic [15:0] div;

    assign strobe = (div == 16'(SCAN_DIV - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div <= '0;
        end else if (strobe) begin
            div <= '0;
        end else begin
            div <= div + 16'd1;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-sequenced keypad scanner with press/release debounce.
//   state       | meaning
//   SCAN        | rotating column strobe, looking for a single low row
//   DEBOUNCE    | column frozen, counting identical samples of the candidate
//   HELD        | key reported, waiting for all rows high
//   RELEASE     | counting consecutive all-high samples
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] key_code,
    output logic       key_valid,
    output logic       keypr
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CNT - 1);

    logic [1:0] state;
    logic [3:0] row_lat;
    logic [7:0] match_cnt;
    logic [7:0] rel_cnt;
    logic       strobe;

    keypad_scan_div #(.SCAN_DIV(SCAN_DIV)) u_div (
        .CLK    (CLK),
        .RST    (RST),
        .strobe (strobe)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_SCAN;
            col       <= COL_C1;
            row_lat   <= 4'hF;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_code  <= KEY_NONE;
            key_valid <= 1'b0;
            keypr     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (strobe) begin
                case (state)
                    ST_SCAN: begin
                        if (one_low(row)) begin
                            row_lat <= row;
                            if (DEBOUNCE_CNT == 1) begin
                                key_code  <= decode_key(row, col);
                                key_valid <= 1'b1;
                                keypr     <= 1'b1;
                                state     <= ST_HELD;
                            end else begin
                                match_cnt <= 8'd1;
                                state     <= ST_DEBOUNCE;
                            end
                        end else begin
                            col <= {col[2:0], col[3]};
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (row == row_lat) begin
                            if (match_cnt == CNT_LAST) begin
                                key_code  <= decode_key(row, col);
                                key_valid <= 1'b1;
                                keypr     <= 1'b1;
                                match_cnt <= '0;
                                state     <= ST_HELD;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                            col       <= {col[2:0], col[3]};
                            state     <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        // Other keys in the same column keep us here; only all-high counts.
                        if (row == 4'hF) begin
                            if (DEBOUNCE_CNT == 1) begin
                                key_code <= KEY_NONE;
                                keypr    <= 1'b0;
                                col      <= {col[2:0], col[3]};
                                state    <= ST_SCAN;
                            end else begin
                                rel_cnt <= 8'd1;
                                state   <= ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (row == 4'hF) begin
                            if (rel_cnt == CNT_LAST) begin
                                key_code <= KEY_NONE;
                                keypr    <= 1'b0;
                                rel_cnt  <= '0;
                                col      <= {col[2:0], col[3]};
                                state    <= ST_SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + 8'd1;
                            end
                        end else begin
                            rel_cnt <= '0;
                            state   <= ST_HELD;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad switch model drives the rows from the
// column strobes; a key-level reference model predicts every output cycle.
module tb_keypad_scan_ctrl;

    localparam int S = 4;
    localparam int D = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [4:0] key_code;
    logic       key_valid;
    logic       keypr;

    logic [15:0] pressed = 16'h0;   // bit r*4+c = switch at row r, column c closed

    int checks = 0;
    int errors = 0;
    int timeouts = 0;
    int phase = 0;
    int phase_seen = 0;
    int dut_pulses = 0;

    // Reference model state, in key/column terms
    int m_edge = 0;
    int m_col = 0;
    int m_held = -1;
    int m_cand = -1;
    int m_cnt = 0;
    logic [4:0] e_code = 5'h10;
    logic       e_valid = 1'b0;
    logic       e_keypr = 1'b0;
    logic [3:0] e_col;

    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_scan_ctrl #(.SCAN_DIV(S), .DEBOUNCE_CNT(D)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .keypr     (keypr)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (p[i*4+j] && !c[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign row = rows_for(pressed, col);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Checker and reference model: compare the current cycle, then predict the next edge
    initial begin
        int n;
        int idx;
        forever begin
            @(negedge CLK);
            if (RST) begin
                chk("rst_col", col, 4'b1110);
                chk("rst_code", key_code, 5'h10);
                chk("rst_valid", key_valid, 0);
                chk("rst_keypr", keypr, 0);
                m_edge = 0; m_col = 0; m_held = -1; m_cand = -1; m_cnt = 0;
                e_code = 5'h10; e_valid = 1'b0; e_keypr = 1'b0;
            end else begin
                e_col = 4'hF;
                e_col[m_col] = 1'b0;
                chk("col", col, e_col);
                chk("key_code", key_code, e_code);
                chk("key_valid", key_valid, e_valid);
                chk("keypr", keypr, e_keypr);
                if (key_valid === 1'b1) dut_pulses++;

                e_valid = 1'b0;
                if (m_edge % S == S - 1) begin
                    n = 0;
                    idx = -1;
                    for (int r = 0; r < 4; r++)
                        if (pressed[r*4+m_col]) begin
                            n++;
                            idx = r * 4 + m_col;
                        end
                    if (m_held < 0) begin
                        if (n == 1 && (m_cnt == 0 || idx == m_cand)) begin
                            m_cand = idx;
                            m_cnt++;
                            if (m_cnt == D) begin
                                m_held = m_cand;
                                m_cnt = 0;
                                e_code = 5'(keymap[m_held]);
                                e_valid = 1'b1;
                                e_keypr = 1'b1;
                            end
                        end else begin
                            m_cnt = 0;
                            m_col = (m_col + 1) % 4;
                        end
                    end else if (n == 0) begin
                        m_cnt++;
                        if (m_cnt == D) begin
                            m_held = -1;
                            m_cnt = 0;
                            e_code = 5'h10;
                            e_keypr = 1'b0;
                            m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_cnt = 0;
                    end
                end
                m_edge++;
            end

            if (phase != phase_seen) begin
                phase_seen = phase;
                if (phase == 1) chk("directed_pulses", dut_pulses, 5);
                if (phase == 2) chk("wait_timeouts", timeouts, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic wait_held(input bit want);
        int t;
        t = 0;
        while (((m_held >= 0) != want) && t < 500) begin
            tick(1);
            t++;
        end
        if (t >= 500) timeouts++;
    endtask

    initial begin
        int t;
        int kind;
        tick(3);
        RST = 1'b0;
        tick(5);

        // clean press r2c3
        pressed = 16'h0040;
        wait_held(1);
        tick(20);
        pressed = 16'h0;
        wait_held(0);
        tick(8);

        // bounce on r4c4: drop after two matching samples, then hold
        pressed = 16'h8000;
        t = 0;
        while (!(m_held < 0 && m_cnt == 2) && t < 500) begin
            tick(1);
            t++;
        end
        if (t >= 500) timeouts++;
        pressed = 16'h0;
        tick(3 * S);
        pressed = 16'h8000;
        tick(60);
        pressed = 16'h0;
        wait_held(0);
        tick(8);

        // release of r1c1 with one bounce back low
        pressed = 16'h0001;
        wait_held(1);
        tick(6);
        pressed = 16'h0;
        t = 0;
        while (!(m_held >= 0 && m_cnt == 1) && t < 500) begin
            tick(1);
            t++;
        end
        if (t >= 500) timeouts++;
        pressed = 16'h0001;
        tick(S);
        pressed = 16'h0;
        wait_held(0);
        tick(8);

        // ghost: r1c2 + r2c2 give rows 1100 on c2
        pressed = 16'h0022;
        tick(40);
        pressed = 16'h0;
        tick(8);

        // reset while r3c2 is held, key stays down and is reported again
        pressed = 16'h0200;
        wait_held(1);
        tick(5);
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        wait_held(1);
        tick(10);
        pressed = 16'h0;
        wait_held(0);
        tick(8);

        phase = 1;
        tick(2);

        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       pressed = 16'h0;
                1, 2:    pressed = 16'h1 << $urandom_range(0, 15);
                default: pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            tick($urandom_range(1, 30));
            if ($urandom_range(0, 19) == 0) begin
                RST = 1'b1;
                tick(2);
                RST = 1'b0;
            end
        end
        pressed = 16'h0;
        tick(30);

        phase = 2;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Active scan controller for the 4x4 matrix keypad: drives the column strobes, samples the row lines, debounces, and emits one registered key code per press. Replaces free-running `{row,col}` sampling with a sequenced scan so only one column is driven low at a time. Output code space matches the existing keypad decoder: 0x0–0xF for keys, 5'b10000 for no key. Sits between the keypad pins (rows synchronised upstream) and the display/entry logic.

## Interface
- `SCAN_DIV`, 4: CLK cycles each column is held before its row sample; legal range 2–65535.
- `DEBOUNCE_CNT`, 3: consecutive matching samples required to accept a press or a release; legal range 1–255.

- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `row`  in  4  row lines, active-low, pulled up; already synchronised to CLK.
- `col`  out  4  column strobes, one-hot active-low (1110, 1101, 1011, 0111 = c1..c4).
- `key_code`  out  5  accepted key code; 5'b10000 when no key held.
- `key_valid`  out  1  one-cycle pulse when a new press is accepted.
- `keypr`  out  1  level, high while an accepted key is held.

## Operation
- Key map (row bit 0 = r1, col bit 0 = c1): r1: 1,2,3,A; r2: 4,5,6,B; r3: 7,8,9,C; r4: E,0,F,D.
- Prescaler `div` counts 0..SCAN_DIV-1 and wraps; sample strobe when `div == SCAN_DIV-1`. `div` runs in all states.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: on strobe, if `row` has exactly one bit low, latch row/col, set `match_cnt = 1`, column held; go DEBOUNCE (or straight to HELD-accept if DEBOUNCE_CNT = 1). Otherwise (all high, or two or more bits low = ghost/multi-key) advance column c1→c2→c3→c4→c1.
- DEBOUNCE: column held. On strobe, row equal to latched → `match_cnt++`; reaching DEBOUNCE_CNT → accept. Any other row value → SCAN, column advances.
- Accept: next cycle `key_code` = decoded value, `key_valid` = 1 for one cycle, `keypr` = 1; state HELD.
- HELD: column held. On strobe, row all-high → RELEASE with `rel_cnt = 1` (DEBOUNCE_CNT = 1: release immediately). Any other value (same key, second key in same column) → stay; no new `key_valid`.
- RELEASE: on strobe, all-high → `rel_cnt++`; reaching DEBOUNCE_CNT → `keypr` = 0, `key_code` = 5'b10000, SCAN, column advances. Not all-high → HELD, `rel_cnt` cleared.
- Only one key accepted at a time; keys in other columns are invisible while HELD.

## Timing
- Reset (async, immediate): state SCAN, `col` = 1110, `div` = 0, counters 0, `key_code` = 5'b10000, `key_valid` = 0, `keypr` = 0.
- First edge after RST deasserts is cycle 0 with `div` = 0; strobes at cycles SCAN_DIV-1, 2·SCAN_DIV-1, …
- Column change takes effect on the edge after the strobe; row then has SCAN_DIV-1 cycles to settle.
- Press latency from first detecting strobe: (DEBOUNCE_CNT-1)·SCAN_DIV + 1 cycles to `key_valid`.
- `key_valid`, `key_code`, `keypr` are registered; `key_code` changes only on accept and on release completion.
- RST mid-press: all outputs return to reset values; a still-held key is re-detected and re-reported as a new press.

## Structure
- Shared package `keypad_pkg`: `KEY_NONE` = 5'b10000, 16 key-code constants, state encoding, column one-hot constants, `decode_key(row,col)` function (returns KEY_NONE for invalid patterns).
- One sub-module: `keypad_scan_div` — parameterised prescaler producing the sample strobe.

## Test plan
- Reset: RST high mid-cycle → `col` = 1110, `key_code` = 10000, `key_valid` = 0, `keypr` = 0 without waiting for a clock.
- Clean press r2c3 (row = 1101 when `col` = 1011), SCAN_DIV = 4, DEBOUNCE_CNT = 3 → one `key_valid` pulse with `key_code` = 5'b00110, `keypr` = 1, `col` frozen at 1011; latency 9 cycles from detecting strobe.
- Bounce: r4c4 press released after 2 samples, then held → first attempt discarded, scan resumes; later exactly one pulse with code 5'b01101.
- Release: hold r1c1 then release with one bounce back low → `keypr` stays 1 until 3 consecutive all-high samples, then `key_code` = 10000, column advances to 1101.
- Ghost: rows 1100 on c2 → no DEBOUNCE entry, scan continues, no `key_valid`.
- Reset during HELD with r3c2 still pressed → outputs cleared; after re-debounce a fresh pulse with code 5'b01000.
